// File: rtl/rr_request_agent_if.sv
// Request/grant/stall bundle between client work sources, the rr_request_agent and the arbiter.
// master: the agent side; slave: the clients/arbiter side.
interface rr_request_agent_if #(
  parameter int CLIENTS = 32,
  parameter int WAIT_W  = 6,
  parameter int ID_W    = 5
);
  logic [CLIENTS-1:0] work_valid;
  logic [CLIENTS-1:0] work_ready;
  logic [CLIENTS-1:0] request;
  logic [CLIENTS-1:0] grant;
  logic               stall;
  logic [CLIENTS-1:0] served;
  logic [CLIENTS-1:0] starve;
  logic               starve_clear;
  logic               protocol_err;
  logic [WAIT_W-1:0]  max_wait;
  logic [ID_W-1:0]    max_wait_id;

  modport master (
    input  work_valid, grant, stall, starve_clear,
    output work_ready, request, served, starve, protocol_err, max_wait, max_wait_id
  );

  modport slave (
    output work_valid, grant, stall, starve_clear,
    input  work_ready, request, served, starve, protocol_err, max_wait, max_wait_id
  );
endinterface

// File: rtl/rr_request_agent.sv
// Requester-side agent for a round-robin arbiter: per-client pending-job counters, held requests,
// wait/starvation tracking and grant-protocol checking. Worst-wait statistics under RR_REQ_WAIT_STATS_EN.
module rr_request_agent #(
  parameter int CLIENTS  = 32,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = $clog2(DEPTH + 1),
  parameter int MAX_WAIT = 31,
  parameter int WAIT_W   = $clog2(MAX_WAIT + 2)
) (
  input logic               clock,
  input logic               reset_n,
  rr_request_agent_if.master bus
);
  localparam int ID_W = (CLIENTS > 1) ? $clog2(CLIENTS) : 1;
  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_SAT   = '1;

  logic [CNT_W-1:0]   pending  [CLIENTS];
  logic [WAIT_W-1:0]  wait_cnt [CLIENTS];
  logic [CLIENTS-1:0] served_p1;
  logic [CLIENTS-1:0] starve_r;
  logic               protocol_err_r;

  logic [CLIENTS-1:0] ready_c;
  logic [CLIENTS-1:0] request_c;
  logic [CLIENTS-1:0] accept;
  logic [CLIENTS-1:0] consume;
  logic [CLIENTS-1:0] starve_set;
  logic               multi_hot;
  logic               grant_bad;

  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    return (v == WAIT_SAT) ? v : v + WAIT_W'(1);
  endfunction

  // Request and ready decode purely from registered counts: no grant-to-request path.
  always_comb begin
    ready_c    = '0;
    request_c  = '0;
    starve_set = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      ready_c[i]   = (pending[i] != DEPTH_C);
      request_c[i] = (pending[i] != '0);
    end
    accept  = bus.work_valid & ready_c;
    consume = bus.grant & request_c & {CLIENTS{~bus.stall}};
    for (int i = 0; i < CLIENTS; i++) begin
      starve_set[i] = request_c[i] & ~consume[i] & ~bus.stall & (wait_cnt[i] >= MAX_WAIT_C);
    end
    multi_hot = |(bus.grant & (bus.grant - CLIENTS'(1)));
    grant_bad = ~bus.stall & (multi_hot | (|(bus.grant & ~request_c)));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CLIENTS; i++) begin
        pending[i]  <= '0;
        wait_cnt[i] <= '0;
      end
      served_p1      <= '0;
      starve_r       <= '0;
      protocol_err_r <= 1'b0;
    end else begin
      for (int i = 0; i < CLIENTS; i++) begin
        if (accept[i] && !consume[i])
          pending[i] <= pending[i] + CNT_W'(1);
        else if (!accept[i] && consume[i])
          pending[i] <= pending[i] - CNT_W'(1);

        if (consume[i] || !request_c[i])
          wait_cnt[i] <= '0;
        else if (!bus.stall)
          wait_cnt[i] <= sat_inc(wait_cnt[i]);
      end
      served_p1      <= consume;
      // A set in the same cycle as a clear survives so no starvation event is lost.
      starve_r       <= starve_set | (starve_r & ~{CLIENTS{bus.starve_clear}});
      protocol_err_r <= protocol_err_r | grant_bad;
    end
  end

`ifdef RR_REQ_WAIT_STATS_EN
  logic              stat_hit;
  logic [ID_W-1:0]   stat_id;
  logic [WAIT_W-1:0] stat_wait;
  logic [WAIT_W-1:0] max_wait_r;
  logic [ID_W-1:0]   max_wait_id_r;

  // Scan high-to-low so the lowest consuming index wins on an (illegal) multi-hot grant.
  always_comb begin
    stat_hit  = 1'b0;
    stat_id   = '0;
    stat_wait = '0;
    for (int i = CLIENTS - 1; i >= 0; i--) begin
      if (consume[i]) begin
        stat_hit  = 1'b1;
        stat_id   = ID_W'(i);
        stat_wait = wait_cnt[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      max_wait_r    <= '0;
      max_wait_id_r <= '0;
    end else if (stat_hit && (stat_wait > max_wait_r)) begin
      max_wait_r    <= stat_wait;
      max_wait_id_r <= stat_id;
    end
  end

  assign bus.max_wait    = max_wait_r;
  assign bus.max_wait_id = max_wait_id_r;
`else
  assign bus.max_wait    = '0;
  assign bus.max_wait_id = '0;
`endif

  assign bus.work_ready   = ready_c;
  assign bus.request      = request_c;
  assign bus.served       = served_p1;
  assign bus.starve       = starve_r;
  assign bus.protocol_err = protocol_err_r;
endmodule

// File: tb/tb_rr_request_agent.sv
// Directed bench for rr_request_agent with CLIENTS=4, DEPTH=2, MAX_WAIT=3.
module tb_rr_request_agent;
  logic clock;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  rr_request_agent_if #(.CLIENTS(4), .WAIT_W(3), .ID_W(2)) bus ();

  rr_request_agent #(.CLIENTS(4), .DEPTH(2), .MAX_WAIT(3)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [2:0] exp_mw1, exp_mw2;
  logic [1:0] exp_id1, exp_id2;

  initial begin
`ifdef RR_REQ_WAIT_STATS_EN
    exp_mw1 = 3'd1; exp_id1 = 2'd1;
    exp_mw2 = 3'd3; exp_id2 = 2'd2;
`else
    exp_mw1 = 3'd0; exp_id1 = 2'd0;
    exp_mw2 = 3'd0; exp_id2 = 2'd0;
`endif
    bus.work_valid   = '0;
    bus.grant        = '0;
    bus.stall        = 1'b0;
    bus.starve_clear = 1'b0;
    reset_n          = 1'b1;
    #1 reset_n = 1'b0;
    #3;
    chk("rst_request", bus.request, 4'h0);
    chk("rst_ready", bus.work_ready, 4'hF);
    chk("rst_served", bus.served, 4'h0);
    chk("rst_starve", bus.starve, 4'h0);
    chk("rst_perr", bus.protocol_err, 1'b0);
    chk("rst_maxwait", bus.max_wait, 3'd0);
    #18 reset_n = 1'b1;
    tick();

    // Single job on client 1, granted at wait index 2.
    bus.work_valid = 4'b0010;
    tick();
    bus.work_valid = 4'b0000;
    chk("single_req_c1", bus.request, 4'b0010);
    tick();
    chk("single_req_c2", bus.request, 4'b0010);
    tick();
    chk("single_req_c3", bus.request, 4'b0010);
    bus.grant = 4'b0010;
    tick();
    bus.grant = 4'b0000;
    chk("single_served", bus.served, 4'b0010);
    chk("single_req_drop", bus.request, 4'b0000);
    tick();
    chk("single_served_once", bus.served, 4'b0000);
    chk("single_starve", bus.starve, 4'b0000);

    // Fill client 0 to DEPTH, third strobe refused, then drain back-to-back.
    bus.work_valid = 4'b0001;
    tick();
    chk("full_ready1", bus.work_ready, 4'b1111);
    tick();
    chk("full_ready2", bus.work_ready, 4'b1110);
    tick();
    chk("full_ready3", bus.work_ready, 4'b1110);
    bus.work_valid = 4'b0000;
    bus.grant      = 4'b0001;
    tick();
    chk("b2b_req_hold", bus.request, 4'b0001);
    chk("b2b_served1", bus.served, 4'b0001);
    tick();
    bus.grant = 4'b0000;
    chk("b2b_req_drop", bus.request, 4'b0000);
    chk("b2b_served2", bus.served, 4'b0001);
    tick();
    chk("b2b_served_end", bus.served, 4'b0000);
    chk("b2b_starve", bus.starve, 4'b0000);
    chk("b2b_ready", bus.work_ready, 4'b1111);

    // Client 2 granted at wait index 3: legal.
    bus.work_valid = 4'b0100;
    tick();
    bus.work_valid = 4'b0000;
    tick(); tick(); tick();
    bus.grant = 4'b0100;
    tick();
    bus.grant = 4'b0000;
    chk("wait3_served", bus.served, 4'b0100);
    chk("wait3_starve", bus.starve, 4'b0000);

    // Client 2 granted at wait index 4: starvation flagged and sticky.
    bus.work_valid = 4'b0100;
    tick();
    bus.work_valid = 4'b0000;
    tick(); tick(); tick();
    chk("wait3_nostarve_yet", bus.starve, 4'b0000);
    tick();
    chk("wait4_starve", bus.starve, 4'b0100);
    bus.grant = 4'b0100;
    tick();
    bus.grant = 4'b0000;
    chk("wait4_served", bus.served, 4'b0100);
    chk("wait4_sticky", bus.starve, 4'b0100);
    bus.starve_clear = 1'b1;
    tick();
    bus.starve_clear = 1'b0;
    chk("starve_clear", bus.starve, 4'b0000);

    // Stall: grants (even bad ones) ignored; wait frozen so a later grant at index 3 is legal.
    bus.work_valid = 4'b1000;
    tick();
    bus.work_valid = 4'b0000;
    bus.stall      = 1'b1;
    bus.grant      = 4'b1001;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_no_served", bus.served, 4'b0000);
    end
    chk("stall_req_held", bus.request, 4'b1000);
    chk("stall_no_perr", bus.protocol_err, 1'b0);
    bus.stall = 1'b0;
    bus.grant = 4'b0000;
    tick(); tick(); tick();
    bus.grant = 4'b1000;
    tick();
    bus.grant = 4'b0000;
    chk("stall_served", bus.served, 4'b1000);
    chk("stall_starve", bus.starve, 4'b0000);
    chk("stall_req_drop", bus.request, 4'b0000);

    // Multi-hot grant on two requesting clients.
    bus.work_valid = 4'b0011;
    tick();
    bus.work_valid = 4'b0000;
    chk("perr_before", bus.protocol_err, 1'b0);
    bus.grant = 4'b0011;
    tick();
    bus.grant = 4'b0000;
    chk("perr_multihot", bus.protocol_err, 1'b1);
    tick(); tick();
    chk("perr_sticky", bus.protocol_err, 1'b1);

    // Asynchronous reset mid-run clears everything immediately.
    #3 reset_n = 1'b0;
    #1;
    chk("async_rst_perr", bus.protocol_err, 1'b0);
    chk("async_rst_req", bus.request, 4'b0000);
    #2 reset_n = 1'b1;
    tick();

    // Grant to an idle client: error, no served pulse.
    bus.grant = 4'b0100;
    tick();
    bus.grant = 4'b0000;
    chk("idle_grant_perr", bus.protocol_err, 1'b1);
    chk("idle_grant_served", bus.served, 4'b0000);
    chk("idle_grant_req", bus.request, 4'b0000);

    // Reset with a job in flight discards it.
    bus.work_valid = 4'b0001;
    tick();
    bus.work_valid = 4'b0000;
    chk("inflight_req", bus.request, 4'b0001);
    #3 reset_n = 1'b0;
    #1;
    chk("inflight_rst_req", bus.request, 4'b0000);
    chk("inflight_rst_ready", bus.work_ready, 4'b1111);
    chk("inflight_rst_perr", bus.protocol_err, 1'b0);
    chk("inflight_rst_served", bus.served, 4'b0000);
    #2 reset_n = 1'b1;
    tick();
    chk("inflight_after_req", bus.request, 4'b0000);

    // Worst-wait statistics: client 1 at wait 1, then client 2 at wait 3.
    bus.work_valid = 4'b0110;
    tick();
    bus.work_valid = 4'b0000;
    tick();
    bus.grant = 4'b0010;
    tick();
    bus.grant = 4'b0000;
    chk("stats_mw1", bus.max_wait, exp_mw1);
    chk("stats_id1", bus.max_wait_id, exp_id1);
    tick();
    bus.grant = 4'b0100;
    tick();
    bus.grant = 4'b0000;
    chk("stats_served", bus.served, 4'b0100);
    chk("stats_mw2", bus.max_wait, exp_mw2);
    chk("stats_id2", bus.max_wait_id, exp_id2);
    chk("stats_starve", bus.starve, 4'b0000);
    chk("stats_perr", bus.protocol_err, 1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rr_request_agent.md
Name: rr_request_agent

Overview:
- Requester-side agent for the round-robin arbiter's request/grant/stall interface, one lane per client.
- Buffers per-client work as pending-job counters and drives `request[i]` while work is pending. `request[i]` is held until the grant is consumed, which is the hold-request-till-grant rule the arbiter relies on.
- Retires one job per consumed grant and measures request-to-grant wait per client.
- Flags starvation and protocol violations on the grant bus. Sits between client work sources and the arbiter.

Parameters:
- `CLIENTS`, 32, number of requesters; matches the arbiter width.
- `DEPTH`, 4, maximum pending jobs per client (≥1).
- `CNT_W`, `$clog2(DEPTH+1)`, pending counter width.
- `MAX_WAIT`, 31, largest legal wait index before starvation is flagged (CLIENTS-1 for a fair arbiter).
- `WAIT_W`, `$clog2(MAX_WAIT+2)`, wait counter width.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `work_valid`  in  CLIENTS  per-client new-job strobe.
- `work_ready`  out  CLIENTS  per-client job acceptance.
- `request`  out  CLIENTS  request vector to the arbiter.
- `grant`  in  CLIENTS  grant vector from the arbiter.
- `stall`  in  1  arbiter stall; grants are not consumed while high.
- `served`  out  CLIENTS  one-cycle pulse, job retired.
- `starve`  out  CLIENTS  sticky starvation flag.
- `starve_clear`  in  1  clears all starve flags.
- `protocol_err`  out  1  sticky grant-protocol violation.
- `max_wait`  out  WAIT_W  worst observed wait (optional feature).
- `max_wait_id`  out  `$clog2(CLIENTS)`  client that saw `max_wait` (optional feature).

Behaviour:
- Reset (`reset_n`=0, immediate, any cycle, mid-transaction included): `pending`, `wait`, `served`, `starve`, `protocol_err`, `max_wait`, `max_wait_id` all go to 0. `request`=0; `work_ready`=all 1. In-flight jobs are discarded.
- Signal definitions:
  - `accept[i] = work_valid[i] & work_ready[i]`.
  - `work_ready[i] = (pending[i] != DEPTH)`; no same-cycle bypass on consume.
  - `request[i] = (pending[i] != 0)`. It is decoded from a register, so there is no combinational path from `grant` to `request`.
  - `consume[i] = grant[i] & request[i] & ~stall`.
- Pending counter: `pending[i] <= pending[i] + accept[i] - consume[i]`.
  - Simultaneous accept and consume leaves the count unchanged.
  - The count never exceeds DEPTH and never underflows.
- `served[i] <= consume[i]`: a pulse one cycle after the consuming edge.
- `request[i]` is held high every cycle until the consume that brings `pending` to 0. If `pending` > 1 after a consume, `request` stays high with no gap.
- Wait counter:
  - Counts cycles with `request[i]` high and no consume; it does not advance while `stall`=1.
  - Cleared to 0 on `consume[i]`.
  - Saturates at all-ones.
- Starvation: `starve[i] <= 1` when `request[i] & ~consume[i] & ~stall & (wait[i] >= MAX_WAIT)`.
  - A grant consumed at wait index 0..MAX_WAIT is legal; a grant at MAX_WAIT+1 or later flags starvation.
  - `starve_clear` zeroes all flags. A set in the same cycle wins, so no event is lost.
- `protocol_err <= 1` while `stall`=0 if `grant` is multi-hot, or `grant & ~request` is nonzero. It is sticky until reset. Grants during stall are ignored for both checks and for consume.
- `grant[i]` high when `request[i]`=0: no pending change, no `served` pulse.

Optional Feature:
- Macro: `RR_REQ_WAIT_STATS_EN`.
- When defined: on any consume, if that client's wait exceeds `max_wait`, register the new `max_wait` and `max_wait_id`. For multiple simultaneous consumes (already an error), the lowest index is used.
- When undefined: both ports are present and tied to 0, and no tracking logic is built.

Test Plan:
- Parameters: CLIENTS=4, DEPTH=2, MAX_WAIT=3 unless noted.
- Single job: `work_valid[1]`=1 for 1 cycle; `grant[1]`=1 two cycles later → `request[1]` high 3 cycles, `served[1]` pulses once, `pending`=0, `starve`=0.
- Full and back-to-back: 3 consecutive `work_valid[0]` strobes → `work_ready[0]`=0 on the third (`pending`=2). Grants on 2 consecutive cycles → `request[0]` drops after the second, 2 `served` pulses.
- Starve boundary:
  - Grant at wait index 3 → `starve[2]`=0.
  - Repeat with grant at index 4 → `starve[2]`=1.
  - `starve_clear` → 0.
- Stall: `grant[3]` with `stall`=1 for 5 cycles, then `stall`=0 → no consume or wait growth during stall, `starve[3]`=0, `served` after release.
- Protocol: `grant`=4'b0011 with `stall`=0 → `protocol_err`=1 next cycle and sticky. Grant to an idle client also sets it. Mid-run `reset_n` low → all outputs 0 immediately.
- With `RR_REQ_WAIT_STATS_EN`: client 2 waits 3, client 1 waits 1 → `max_wait`=3, `max_wait_id`=2.
